hazard_detect: RTL and testbench
================================

Name: hazard_detect

Overview:
- Decode-stage hazard detector. It sits directly upstream of the operand hazard multiplexer and drives all of that mux's select lines (RAhz, RBhz, ALU1Ahz/Bhz, ALU2Ahz/Bhz, luiHaz1/2) plus its nop stall input.
- It keeps a 3-deep scoreboard of in-flight destination registers for three stages: stage1 = ALU1/EX, stage2 = ALU2/MEM, stage3 = register writeback.
- It flags each source-operand match per stage and raises a one-cycle load-use stall.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- valid  input  1  decode slot holds a real instruction.
- rs1  input  REG_AW  source register A of the decoding instruction.
- rs2  input  REG_AW  source register B.
- rd  input  REG_AW  destination of the decoding instruction.
- regWrite  input  1  decoding instruction writes rd.
- isLoad  input  1  decoding instruction is a load.
- isLUI  input  1  decoding instruction is LUI.
- RAhz, RBhz  output  1  rs1/rs2 matches stage3.
- ALU2Ahz, ALU2Bhz  output  1  rs1/rs2 matches stage2.
- ALU1Ahz, ALU1Bhz  output  1  rs1/rs2 matches stage1.
- luiHaz1  output  1  stage1 entry is LUI.
- luiHaz2  output  1  stage2 entry is LUI.
- nop  output  1  load-use stall request.
- stallCount  output  CNT_W  number of stalls issued, saturating.

Behaviour:
- Scoreboard: three entries, each {v, rd, wr, ld, lui}.
  - On every posedge: stage3 <= stage2, stage2 <= stage1.
  - stage1 <= decode fields when a valid instruction advances; otherwise stage1 <= bubble (all flags 0).
- Match rule: stage k matches source s iff stage_k.v & stage_k.wr & (stage_k.rd == s) & (s != 0).
  - Register x0 never produces a hazard.
- Hazard outputs are combinational from the current rs1/rs2 and the scoreboard, valid in the same cycle as the decode inputs.
  - Zero latency, because the consuming mux registers on the same edge.
  - ALU1*/ALU2*/R*hz report raw per-stage matches with no prioritisation; the downstream mux resolves precedence (stage1 > stage2 > stage3).
  - All hazard outputs are forced 0 when valid=0.
- luiHaz1 = stage1.v & stage1.lui; luiHaz2 = stage2.v & stage2.lui. Neither depends on rs.
- Load-use stall: nop = valid & stage1.ld & (ALU1Ahz | ALU1Bhz) & ~stallHold.
- Stall FSM, states IDLE and HOLD:
  - IDLE -> HOLD when nop=1. On that edge a bubble enters stage1 and the decoding instruction is NOT captured; the front end re-presents it.
  - HOLD -> IDLE unconditionally on the next edge. The instruction is captured normally on that edge.
  - stallHold = (state==HOLD). In HOLD, nop is forced 0, mirroring the consumer's one-cycle ignore window.
  - In HOLD, hazard outputs are still computed against the shifted scoreboard; the load now sits in stage2, so ALU2*hz is asserted.
- stallCount: +1 on every posedge where nop=1; saturates at all-ones and never wraps.
- Reset (takes priority over all other updates):
  - All scoreboard entries become bubbles, state = IDLE, stallCount = 0.
  - Consequently every output is 0 in the cycle after reset is sampled.
- Reset mid-stall: HOLD is abandoned; no pending capture survives.
- Simultaneous matches, e.g. rs1 matching stage1 and stage3: both ALU1Ahz and RAhz are asserted.
- rs1 == rs2: A-side and B-side flags are identical.

Test Plan:
- Reset, then idle with valid=0 -> all outputs 0, stallCount=0.
- Back-to-back chain:
  - Stimulus: ADD x5 (regWrite), then SUB rs1=x5, rs2=x6.
  - Required: ALU1Ahz=1, ALU1Bhz=0 on the SUB decode cycle.
  - Two more non-writing instructions follow: ALU2Ahz=1 on the 2nd, RAhz=1 on the 3rd.
- Load-use:
  - Stimulus: LW x7, then ADD rs2=x7.
  - Required: nop=1 for exactly one cycle and stallCount=1.
  - Next cycle (HOLD): nop=0, ALU2Bhz=1, ALU1Bhz=0.
  - The following cycle captures the ADD.
- x0 filter: ADDI writing x0 followed by a reader of x0 -> no hazard outputs.
- LUI forward: LUI x3, then reader rs1=x3 -> ALU1Ahz=1, luiHaz1=1. One cycle later: luiHaz2=1.
- Saturation and reset:
  - Force 0xFFFF stalls -> stallCount holds 0xFFFF.
  - Assert rst during HOLD -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/hazard_detect_if.sv
// Decode-to-hazard-detector bundle: decode fields in, operand-mux selects and stall request out.
// Slave modport is the detector; master modport is the decode stage driving it.
interface hazard_detect_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              regWrite;
    logic              isLoad;
    logic              isLUI;

    logic              RAhz;
    logic              RBhz;
    logic              ALU2Ahz;
    logic              ALU2Bhz;
    logic              ALU1Ahz;
    logic              ALU1Bhz;
    logic              luiHaz1;
    logic              luiHaz2;
    logic              nop;
    logic [CNT_W-1:0]  stallCount;

    modport master (
        output valid, rs1, rs2, rd, regWrite, isLoad, isLUI,
        input  RAhz, RBhz, ALU2Ahz, ALU2Bhz, ALU1Ahz, ALU1Bhz,
        input  luiHaz1, luiHaz2, nop, stallCount
    );

    modport slave (
        input  valid, rs1, rs2, rd, regWrite, isLoad, isLUI,
        output RAhz, RBhz, ALU2Ahz, ALU2Bhz, ALU1Ahz, ALU1Bhz,
        output luiHaz1, luiHaz2, nop, stallCount
    );
endinterface

// File: rtl/hazard_detect.sv
// Decode-stage hazard detector over a 3-entry in-flight scoreboard; hazard flags are zero-latency.
// No backpressure input; on a load-use hit it asserts nop for one cycle and drops the decoding slot.
module hazard_detect #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    hazard_detect_if.slave hz
);
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
        logic              lui;
    } ex_entry_t;

    // Later stages only need the fields something still looks at.
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              lui;
    } mem_entry_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wr;
    } wb_entry_t;

    typedef enum logic {IDLE, HOLD} state_t;

    ex_entry_t        stage1_q, stage1_d;
    mem_entry_t       stage2_q;
    wb_entry_t        stage3_q;
    state_t           state_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic a1_hit, b1_hit, a2_hit, b2_hit, a3_hit, b3_hit;
    logic stall_hold, nop_w;

    function automatic logic src_match(input logic v, input logic wr,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] src);
        return v & wr & (rd == src) & (src != '0);
    endfunction

    always_comb begin
        stall_hold = (state_q == HOLD);
        a1_hit = hz.valid & src_match(stage1_q.v, stage1_q.wr, stage1_q.rd, hz.rs1);
        b1_hit = hz.valid & src_match(stage1_q.v, stage1_q.wr, stage1_q.rd, hz.rs2);
        a2_hit = hz.valid & src_match(stage2_q.v, stage2_q.wr, stage2_q.rd, hz.rs1);
        b2_hit = hz.valid & src_match(stage2_q.v, stage2_q.wr, stage2_q.rd, hz.rs2);
        a3_hit = hz.valid & src_match(stage3_q.v, stage3_q.wr, stage3_q.rd, hz.rs1);
        b3_hit = hz.valid & src_match(stage3_q.v, stage3_q.wr, stage3_q.rd, hz.rs2);
        nop_w  = hz.valid & stage1_q.ld & (a1_hit | b1_hit) & ~stall_hold;

        // A stalled instruction is re-presented by the front end, so it must not enter here.
        stage1_d = '0;
        if (hz.valid && !nop_w) begin
            stage1_d.v   = 1'b1;
            stage1_d.rd  = hz.rd;
            stage1_d.wr  = hz.regWrite;
            stage1_d.ld  = hz.isLoad;
            stage1_d.lui = hz.isLUI;
        end

        stall_cnt_d = stall_cnt_q;
        if (nop_w && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign hz.RAhz       = a3_hit;
    assign hz.RBhz       = b3_hit;
    assign hz.ALU2Ahz    = a2_hit;
    assign hz.ALU2Bhz    = b2_hit;
    assign hz.ALU1Ahz    = a1_hit;
    assign hz.ALU1Bhz    = b1_hit;
    assign hz.luiHaz1    = stage1_q.v & stage1_q.lui;
    assign hz.luiHaz2    = stage2_q.v & stage2_q.lui;
    assign hz.nop        = nop_w;
    assign hz.stallCount = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_q    <= '0;
            stage2_q    <= '0;
            stage3_q    <= '0;
            state_q     <= IDLE;
            stall_cnt_q <= '0;
        end else begin
            stage1_q     <= stage1_d;
            stage2_q.v   <= stage1_q.v;
            stage2_q.rd  <= stage1_q.rd;
            stage2_q.wr  <= stage1_q.wr;
            stage2_q.lui <= stage1_q.lui;
            stage3_q.v   <= stage2_q.v;
            stage3_q.rd  <= stage2_q.rd;
            stage3_q.wr  <= stage2_q.wr;
            stall_cnt_q  <= stall_cnt_d;
            case (state_q)
                IDLE:    if (nop_w) state_q <= HOLD;
                HOLD:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_detect.sv
// Directed bench for hazard_detect; a second narrow-counter instance shadows the stimulus for saturation.
module tb_hazard_detect;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    hazard_detect_if #(.REG_AW(5), .CNT_W(16)) hm ();
    hazard_detect_if #(.REG_AW(5), .CNT_W(3))  hs ();

    hazard_detect #(.REG_AW(5), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .hz(hm.slave));
    hazard_detect #(.REG_AW(5), .CNT_W(3))  u_sat (.clk(clk), .rst(rst), .hz(hs.slave));

    assign hs.valid    = hm.valid;
    assign hs.rs1      = hm.rs1;
    assign hs.rs2      = hm.rs2;
    assign hs.rd       = hm.rd;
    assign hs.regWrite = hm.regWrite;
    assign hs.isLoad   = hm.isLoad;
    assign hs.isLUI    = hm.isLUI;

    // {RA, RB, ALU2A, ALU2B, ALU1A, ALU1B, lui1, lui2, nop}
    logic [8:0] outs;
    assign outs = {hm.RAhz, hm.RBhz, hm.ALU2Ahz, hm.ALU2Bhz, hm.ALU1Ahz, hm.ALU1Bhz,
                   hm.luiHaz1, hm.luiHaz2, hm.nop};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic w, input logic l, input logic u);
        hm.valid    = v;
        hm.rs1      = a;
        hm.rs2      = b;
        hm.rd       = d;
        hm.regWrite = w;
        hm.isLoad   = l;
        hm.isLUI    = u;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one edge, present a decode slot, then sample on the falling edge.
    task automatic cyc_in(input logic v, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic w, input logic l, input logic u);
        tick();
        drive(v, a, b, d, w, l, u);
        @(negedge clk);
    endtask

    initial begin
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        chk("rst_outs", 32'(outs), 32'h0);
        chk("rst_cnt", 32'(hm.stallCount), 32'h0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_outs", 32'(outs), 32'h0);

        // Back-to-back chain through all three stages
        cyc_in(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("add_x5", 32'(outs), 32'h0);
        cyc_in(1'b1, 5'd5, 5'd6, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("sub_alu1", 32'(outs), 32'(9'b00_00_10_00_0));
        cyc_in(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("st_alu2", 32'(outs), 32'(9'b00_10_00_00_0));
        cyc_in(1'b1, 5'd5, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("st_ra_alu2b", 32'(outs), 32'(9'b10_01_00_00_0));
        cyc_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("rs_equal", 32'(outs), 32'(9'b11_00_00_00_0));

        // Load-use stall
        cyc_in(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        chk("lw_x7", 32'(outs), 32'h0);
        cyc_in(1'b1, 5'd2, 5'd7, 5'd10, 1'b1, 1'b0, 1'b0);
        chk("lu_stall", 32'(outs), 32'(9'b00_00_01_00_1));
        chk("lu_cnt0", 32'(hm.stallCount), 32'h0);
        cyc_in(1'b1, 5'd2, 5'd7, 5'd10, 1'b1, 1'b0, 1'b0);
        chk("lu_hold", 32'(outs), 32'(9'b00_01_00_00_0));
        chk("lu_cnt1", 32'(hm.stallCount), 32'h1);
        cyc_in(1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_captured", 32'(outs), 32'(9'b00_00_10_00_0));

        // x0 never hazards
        cyc_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("addi_x0", 32'(outs), 32'h0);
        cyc_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("read_x0", 32'(outs), 32'h0);

        // LUI forward
        cyc_in(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1);
        chk("lui_x3", 32'(outs), 32'h0);
        cyc_in(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lui_haz1", 32'(outs), 32'(9'b00_00_10_10_0));
        cyc_in(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lui_haz2", 32'(outs), 32'(9'b00_11_00_01_0));
        #2;
        hm.valid = 1'b0;
        #1;
        chk("valid0_gate", 32'({outs[8:3], outs[0]}), 32'h0);

        // Repeated load-use stalls; narrow instance must pin at its all-ones value
        for (int i = 0; i < 9; i++) begin
            cyc_in(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
            cyc_in(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("loop_nop%0d", i), 32'(hm.nop), 32'h1);
            cyc_in(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("loop_hold%0d", i), 32'(hm.nop), 32'h0);
        end
        chk("cnt_main", 32'(hm.stallCount), 32'd10);
        chk("cnt_sat", 32'(hs.stallCount), 32'd7);

        // Reset while in HOLD
        cyc_in(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        cyc_in(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("rh_nop", 32'(outs), 32'(9'b00_00_10_00_1));
        cyc_in(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("rh_hold", 32'(outs), 32'(9'b00_10_00_00_0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rh_outs", 32'(outs), 32'h0);
        chk("rh_cnt", 32'(hm.stallCount), 32'h0);
        chk("rh_cnt_sat", 32'(hs.stallCount), 32'h0);
        cyc_in(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        chk("rh_lw_x8", 32'(outs), 32'h0);
        cyc_in(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("rh_idle_stall", 32'(outs), 32'(9'b00_00_10_00_1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
